// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and link-fault encodings for the
// link fault block.
package xgmii_pkg;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } link_fault_t;

    localparam logic [7:0] XGMII_IDLE    = 8'h07;
    localparam logic [7:0] XGMII_SEQ     = 8'h9C;
    localparam logic [7:0] XGMII_LF_CODE = 8'h01;
    localparam logic [7:0] XGMII_RF_CODE = 8'h02;

    localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_CTRL = 8'hFF;
    localparam logic [63:0] RF_WORD   = 64'h0200009C_0200009C;
    localparam logic [7:0]  RF_CTRL   = 8'h11;

endpackage

// File: rtl/xgmii_link_fault_if.sv
// XGMII bundle around the link fault block: PHY/MAC side drives
// the *_in signals, the block drives the *_out and status signals.
interface xgmii_link_fault_if;

    logic [63:0] xgmii_rxd_in;
    logic [7:0]  xgmii_rxc_in;
    logic [63:0] xgmii_rxd_out;
    logic [7:0]  xgmii_rxc_out;
    logic [63:0] xgmii_txd_in;
    logic [7:0]  xgmii_txc_in;
    logic [63:0] xgmii_txd_out;
    logic [7:0]  xgmii_txc_out;
    logic [1:0]  link_fault;
    logic [31:0] local_fault_cnt;
    logic [31:0] remote_fault_cnt;

    modport master (
        output xgmii_rxd_in, xgmii_rxc_in,
        output xgmii_txd_in, xgmii_txc_in,
        input  xgmii_rxd_out, xgmii_rxc_out,
        input  xgmii_txd_out, xgmii_txc_out,
        input  link_fault,
        input  local_fault_cnt, remote_fault_cnt
    );

    modport slave (
        input  xgmii_rxd_in, xgmii_rxc_in,
        input  xgmii_txd_in, xgmii_txc_in,
        output xgmii_rxd_out, xgmii_rxc_out,
        output xgmii_txd_out, xgmii_txc_out,
        output link_fault,
        output local_fault_cnt, remote_fault_cnt
    );

endinterface

// File: rtl/xgmii_seq_detect.sv
// Decodes one 4-lane XGMII column into a fault sequence flag
// and its type (LOCAL or REMOTE).
module xgmii_seq_detect
    import xgmii_pkg::*;
(
    input  logic [31:0] col_d,
    input  logic [3:0]  col_c,
    output logic        is_seq,
    output link_fault_t seq_kind
);

    logic hdr_ok;
    logic is_lf;
    logic is_rf;

    assign hdr_ok = (col_c == 4'b0001) &&
                    (col_d[7:0] == XGMII_SEQ) &&
                    (col_d[23:8] == 16'h0000);
    assign is_lf = (col_d[31:24] == XGMII_LF_CODE);
    assign is_rf = (col_d[31:24] == XGMII_RF_CODE);

    assign is_seq   = hdr_ok && (is_lf || is_rf);
    assign seq_kind = is_rf ? LF_REMOTE : LF_LOCAL;

endmodule

// File: rtl/xgmii_link_fault.sv
// XGMII link fault detection and TX fault signalling.
// Optional statistics counters: define XGMII_LF_STATS_EN.
module xgmii_link_fault
    import xgmii_pkg::*;
#(
    parameter int C_COL_WINDOW = 128,
    parameter int C_SEQ_THRESH = 4
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic [63:0] xgmii_rxd_in,
    input  logic [7:0]  xgmii_rxc_in,
    output logic [63:0] xgmii_rxd_out,
    output logic [7:0]  xgmii_rxc_out,
    input  logic [63:0] xgmii_txd_in,
    input  logic [7:0]  xgmii_txc_in,
    output logic [63:0] xgmii_txd_out,
    output logic [7:0]  xgmii_txc_out,
    output logic [1:0]  link_fault,
    output logic [31:0] local_fault_cnt,
    output logic [31:0] remote_fault_cnt
);

    localparam int COL_W = $clog2(C_COL_WINDOW + 1);
    localparam int SEQ_W = $clog2(C_SEQ_THRESH + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(C_COL_WINDOW);
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(C_SEQ_THRESH);

    logic [1:0]       col_seq;
    link_fault_t      col_kind [2];
    link_fault_t      lf_q, lf_d;
    link_fault_t      type_q, type_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [63:0]      txd_d;
    logic [7:0]       txc_d;

    xgmii_seq_detect u_det0 (
        .col_d    (xgmii_rxd_in[31:0]),
        .col_c    (xgmii_rxc_in[3:0]),
        .is_seq   (col_seq[0]),
        .seq_kind (col_kind[0])
    );

    xgmii_seq_detect u_det1 (
        .col_d    (xgmii_rxd_in[63:32]),
        .col_c    (xgmii_rxc_in[7:4]),
        .is_seq   (col_seq[1]),
        .seq_kind (col_kind[1])
    );

    // Column 1 sees the state already updated by column 0.
    always_comb begin
        lf_d   = lf_q;
        type_d = type_q;
        seq_d  = seq_q;
        col_d  = col_q;
        for (int i = 0; i < 2; i++) begin
            if (col_seq[i]) begin
                if (col_kind[i] == type_d) begin
                    if (seq_d != SEQ_MAX)
                        seq_d = seq_d + SEQ_W'(1);
                end else begin
                    type_d = col_kind[i];
                    seq_d  = SEQ_W'(1);
                end
                col_d = '0;
            end else begin
                if (col_d != COL_MAX)
                    col_d = col_d + COL_W'(1);
                if (col_d == COL_MAX) begin
                    seq_d = '0;
                    lf_d  = LF_OK;
                end
            end
            if (seq_d == SEQ_MAX)
                lf_d = type_d;
        end
    end

    always_comb begin
        txd_d = xgmii_txd_in;
        txc_d = xgmii_txc_in;
        unique case (1'b1)
            (lf_q == LF_LOCAL): begin
                txd_d = RF_WORD;
                txc_d = RF_CTRL;
            end
            (lf_q == LF_REMOTE): begin
                txd_d = IDLE_WORD;
                txc_d = IDLE_CTRL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            lf_q          <= LF_OK;
            type_q        <= LF_LOCAL;
            seq_q         <= '0;
            col_q         <= '0;
            xgmii_rxd_out <= IDLE_WORD;
            xgmii_rxc_out <= IDLE_CTRL;
            xgmii_txd_out <= IDLE_WORD;
            xgmii_txc_out <= IDLE_CTRL;
        end else begin
            lf_q          <= lf_d;
            type_q        <= type_d;
            seq_q         <= seq_d;
            col_q         <= col_d;
            xgmii_rxd_out <= xgmii_rxd_in;
            xgmii_rxc_out <= xgmii_rxc_in;
            xgmii_txd_out <= txd_d;
            xgmii_txc_out <= txc_d;
        end
    end

    assign link_fault = lf_q;

`ifdef XGMII_LF_STATS_EN
    logic [31:0] lcnt_q;
    logic [31:0] rcnt_q;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            lcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (lf_d == LF_LOCAL && lf_q != LF_LOCAL &&
                lcnt_q != 32'hFFFF_FFFF)
                lcnt_q <= lcnt_q + 32'd1;
            if (lf_d == LF_REMOTE && lf_q != LF_REMOTE &&
                rcnt_q != 32'hFFFF_FFFF)
                rcnt_q <= rcnt_q + 32'd1;
        end
    end

    assign local_fault_cnt  = lcnt_q;
    assign remote_fault_cnt = rcnt_q;
`else
    assign local_fault_cnt  = 32'd0;
    assign remote_fault_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_xgmii_link_fault.sv
// Scoreboard bench for xgmii_link_fault: directed scenarios plus
// random column bursts against a behavioural link-fault model.
`timescale 1ns/1ps
module tb_xgmii_link_fault;
    import xgmii_pkg::*;

    localparam int WIN = 128;
    localparam int TH  = 4;
`ifdef XGMII_LF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [63:0] rxd;
        logic [7:0]  rxc;
        logic [63:0] txd;
        logic [7:0]  txc;
        logic [1:0]  lf;
        logic [31:0] lcnt;
        logic [31:0] rcnt;
    } exp_t;

    logic clk156 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk156 = ~clk156;

    xgmii_link_fault_if bus ();

    xgmii_link_fault #(
        .C_COL_WINDOW (WIN),
        .C_SEQ_THRESH (TH)
    ) dut (
        .clk156           (clk156),
        .reset            (reset),
        .xgmii_rxd_in     (bus.xgmii_rxd_in),
        .xgmii_rxc_in     (bus.xgmii_rxc_in),
        .xgmii_rxd_out    (bus.xgmii_rxd_out),
        .xgmii_rxc_out    (bus.xgmii_rxc_out),
        .xgmii_txd_in     (bus.xgmii_txd_in),
        .xgmii_txc_in     (bus.xgmii_txc_in),
        .xgmii_txd_out    (bus.xgmii_txd_out),
        .xgmii_txc_out    (bus.xgmii_txc_out),
        .link_fault       (bus.link_fault),
        .local_fault_cnt  (bus.local_fault_cnt),
        .remote_fault_cnt (bus.remote_fault_cnt)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: run = consecutive same-type sequences, gap = columns
    // since the last sequence (both unbounded).
    int m_lf, m_type, m_run, m_gap;
    int m_lcnt, m_rcnt;

    function automatic int col_fault(logic [31:0] d, logic [3:0] c);
        if (c != 4'b0001)      return 0;
        if (d[7:0] != 8'h9C)   return 0;
        if (d[15:8] != 8'h00)  return 0;
        if (d[23:16] != 8'h00) return 0;
        if (d[31:24] == 8'h01) return 1;
        if (d[31:24] == 8'h02) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_lf = 0; m_type = 1; m_run = 0; m_gap = 0;
        m_lcnt = 0; m_rcnt = 0;
    endtask

    task automatic model_cycle(input logic [63:0] rxd,
                               input logic [7:0] rxc,
                               input logic [63:0] txd,
                               input logic [7:0] txc,
                               output exp_t e);
        int old, f;
        e.rxd = rxd;
        e.rxc = rxc;
        if (m_lf == 1) begin
            e.txd = 64'h0200009C_0200009C; e.txc = 8'h11;
        end else if (m_lf == 2) begin
            e.txd = 64'h07070707_07070707; e.txc = 8'hFF;
        end else begin
            e.txd = txd; e.txc = txc;
        end
        old = m_lf;
        for (int c = 0; c < 2; c++) begin
            f = col_fault(rxd[32*c +: 32], rxc[4*c +: 4]);
            if (f != 0) begin
                if (f == m_type) m_run++;
                else begin m_type = f; m_run = 1; end
                m_gap = 0;
                if (m_run >= TH) m_lf = m_type;
            end else begin
                m_gap++;
                if (m_gap >= WIN) begin m_run = 0; m_lf = 0; end
            end
        end
        if (STATS && m_lf == 1 && old != 1) m_lcnt++;
        if (STATS && m_lf == 2 && old != 2) m_rcnt++;
        e.lf   = 2'(m_lf);
        e.lcnt = 32'(m_lcnt);
        e.rcnt = 32'(m_rcnt);
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.rxd = 64'h07070707_07070707; e.rxc = 8'hFF;
        e.txd = 64'h07070707_07070707; e.txc = 8'hFF;
        e.lf = 2'b00; e.lcnt = 32'd0; e.rcnt = 32'd0;
        return e;
    endfunction

    // kinds: 0 idle, 1 LF, 2 RF, 3 data, 4 near-miss seq, 5 random
    function automatic logic [35:0] mk_col(int kind);
        logic [35:0] v;
        case (kind)
            0: v = {4'hF, 32'h07070707};
            1: v = {4'h1, 32'h0100009C};
            2: v = {4'h1, 32'h0200009C};
            3: v = {4'h0, 32'($urandom)};
            4: begin
                v = ($urandom_range(0, 1) == 0) ? {4'h1, 32'h0100009C}
                                                 : {4'h1, 32'h0200009C};
                v = v ^ (36'd1 << $urandom_range(0, 35));
            end
            default: v = {4'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    task automatic drive(input int k0, input int k1,
                         input logic [63:0] txd,
                         input logic [7:0] txc);
        logic [35:0] c0, c1;
        logic [63:0] rxd;
        logic [7:0]  rxc;
        exp_t        e;
        c0 = mk_col(k0);
        c1 = mk_col(k1);
        rxd = {c1[31:0], c0[31:0]};
        rxc = {c1[35:32], c0[35:32]};
        @(negedge clk156);
        reset = 1'b0;
        bus.xgmii_rxd_in = rxd;
        bus.xgmii_rxc_in = rxc;
        bus.xgmii_txd_in = txd;
        bus.xgmii_txc_in = txc;
        model_cycle(rxd, rxc, txd, txc, e);
        sb.push_back(e);
    endtask

    task automatic drive_r(input int k0, input int k1);
        drive(k0, k1, {32'($urandom), 32'($urandom)}, 8'($urandom));
    endtask

    task automatic reset_cycle();
        @(negedge clk156);
        reset = 1'b1;
        model_reset();
        sb.push_back(reset_exp());
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk156);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rxd_out", bus.xgmii_rxd_out, e.rxd);
                chk("rxc_out", 64'(bus.xgmii_rxc_out), 64'(e.rxc));
                chk("txd_out", bus.xgmii_txd_out, e.txd);
                chk("txc_out", 64'(bus.xgmii_txc_out), 64'(e.txc));
                chk("link_fault", 64'(bus.link_fault), 64'(e.lf));
                chk("local_cnt", 64'(bus.local_fault_cnt), 64'(e.lcnt));
                chk("remote_cnt", 64'(bus.remote_fault_cnt), 64'(e.rcnt));
            end
        end
    end

    initial begin
        int k, len, bk, k0, k1, guard;
        bus.xgmii_rxd_in = 64'h07070707_07070707;
        bus.xgmii_rxc_in = 8'hFF;
        bus.xgmii_txd_in = '0;
        bus.xgmii_txc_in = '0;
        model_reset();
        sb.push_back(reset_exp());
        // LF in column 0 for four cycles, then MAC data
        for (int i = 0; i < 4; i++) drive_r(1, 0);
        for (int i = 0; i < 3; i++) drive_r(3, 3);
        // idle window clears the fault
        for (int i = 0; i < 66; i++) drive_r(0, 0);
        // RF in both columns
        for (int i = 0; i < 2; i++) drive_r(2, 2);
        for (int i = 0; i < 4; i++) drive_r(3, 3);
        // direct REMOTE -> LOCAL switch
        for (int i = 0; i < 2; i++) drive_r(1, 1);
        for (int i = 0; i < 66; i++) drive_r(0, 0);
        // alternating LF/RF for 100 columns
        for (int i = 0; i < 50; i++) drive_r(1, 2);
        // partial count discarded by reset
        for (int i = 0; i < 3; i++) drive_r(1, 0);
        reset_cycle();
        drive_r(1, 0);
        drive_r(3, 3);
        for (int i = 0; i < 3; i++) drive_r(1, 0);
        drive_r(3, 3);
        // OK -> LOCAL -> OK -> REMOTE -> LOCAL
        reset_cycle();
        for (int i = 0; i < 4; i++) drive_r(1, 0);
        for (int i = 0; i < 65; i++) drive_r(0, 0);
        for (int i = 0; i < 2; i++) drive_r(2, 2);
        for (int i = 0; i < 2; i++) drive_r(1, 1);
        drive_r(3, 3);
        // random bursts
        for (int it = 0; it < 600; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)      bk = 1;
            else if (k <= 5) bk = 2;
            else if (k == 6) bk = 0;
            else if (k == 7) bk = 3;
            else if (k == 8) bk = 4;
            else             bk = 5;
            len = (bk == 0) ? $urandom_range(20, 70)
                            : $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                k0 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : bk;
                k1 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : bk;
                drive_r(k0, k1);
            end
            if ($urandom_range(0, 99) == 0) reset_cycle();
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk156);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
